// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_receiver
//  Function : PS/2 keyboard frame receiver (sync, decode, parity/stop check)
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_receiver #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data,
   output logic       valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_DATA   = 2'd1;
   localparam logic [1:0] c_ST_PARITY = 2'd2;
   localparam logic [1:0] c_ST_STOP   = 2'd3;

   localparam int            c_TW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   // Compare against limit-2 so the registered error lands TIMEOUT_CYCLES after the fall
   localparam logic [c_TW-1:0] c_TLIM = c_TW'(TIMEOUT_CYCLES - 2);

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_data_sync;
   logic                   r_clk_d;
   logic [1:0]             r_state;
   logic [1:0]             w_state_nxt;
   logic [7:0]             r_shift;
   logic [2:0]             r_bitcnt;
   logic                   r_pbit;
   logic [c_TW-1:0]        r_tcnt;
   logic                   w_clk_s;
   logic                   w_data_s;
   logic                   w_fall;
   logic                   w_par_ok;
   logic                   w_timeout;
   logic                   w_load;
   logic                   w_perr;
   logic                   w_ferr;

   assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
   assign w_data_s = r_data_sync[SYNC_STAGES-1];
   assign w_fall   = r_clk_d & ~w_clk_s;
   assign w_par_ok = ^r_shift ^ r_pbit;

   // Idle-high bus: sync chain resets to 1 so no false edge follows reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_sync  <= '1;
         r_data_sync <= '1;
         r_clk_d     <= 1'b1;
      end else begin
         r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
         r_clk_d     <= w_clk_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_perr      = 1'b0;
      w_ferr      = 1'b0;
      w_timeout   = (r_tcnt == c_TLIM) && !w_fall;
      case (r_state)
         c_ST_IDLE: begin
            if (w_fall && !w_data_s) w_state_nxt = c_ST_DATA;
         end
         c_ST_DATA: begin
            if (w_fall) begin
               if (r_bitcnt == 3'd7) w_state_nxt = c_ST_PARITY;
            end else if (w_timeout) begin
               w_state_nxt = c_ST_IDLE;
               w_ferr      = 1'b1;
            end
         end
         c_ST_PARITY: begin
            if (w_fall) begin
               w_state_nxt = c_ST_STOP;
            end else if (w_timeout) begin
               w_state_nxt = c_ST_IDLE;
               w_ferr      = 1'b1;
            end
         end
         default: begin
            if (w_fall) begin
               w_state_nxt = c_ST_IDLE;
               if (!w_data_s)     w_ferr = 1'b1;
               else if (w_par_ok) w_load = 1'b1;
               else               w_perr = 1'b1;
            end else if (w_timeout) begin
               w_state_nxt = c_ST_IDLE;
               w_ferr      = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      busy = (r_state != c_ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift    <= 8'h00;
         r_bitcnt   <= 3'd0;
         r_pbit     <= 1'b0;
         r_tcnt     <= '0;
         data       <= 8'h00;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         valid      <= w_load;
         parity_err <= w_perr;
         frame_err  <= w_ferr;
         if (w_load) data <= r_shift;
         if ((r_state == c_ST_IDLE) || w_fall) r_tcnt <= '0;
         else                                  r_tcnt <= r_tcnt + c_TW'(1);
         if (w_fall) begin
            case (r_state)
               c_ST_IDLE:   r_bitcnt <= 3'd0;
               c_ST_DATA: begin
                  r_shift  <= {w_data_s, r_shift[7:1]};
                  r_bitcnt <= r_bitcnt + 3'd1;
               end
               c_ST_PARITY: r_pbit <= w_data_s;
               default:     ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_receiver
//  Function : Directed self-checking bench for ps2_receiver
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_receiver;

   localparam int SYNC = 2;
   localparam int TMO  = 200;
   localparam int HALF = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] data;
   logic       valid, parity_err, frame_err, busy;

   always #5 clk = ~clk;

   ps2_receiver #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .data(data), .valid(valid), .parity_err(parity_err),
      .frame_err(frame_err), .busy(busy)
   );

   typedef struct {
      logic [7:0] d;
      logic       par;
      logic       stop;
      int         ev, ep, ef;
      logic [7:0] ed;
   } vec_t;

   vec_t vt[8];
   int checks = 0, errors = 0;
   int n_valid = 0, n_perr = 0, n_ferr = 0, n_multi = 0;
   int lat;

   // High-cycle counters: a stretched pulse shows up as a count above one
   always @(negedge clk) begin
      if (rst_n) begin
         n_valid = n_valid + int'(valid);
         n_perr  = n_perr + int'(parity_err);
         n_ferr  = n_ferr + int'(frame_err);
         if (int'(valid) + int'(parity_err) + int'(frame_err) > 1) n_multi = n_multi + 1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic clear_counts();
      n_valid = 0; n_perr = 0; n_ferr = 0; n_multi = 0;
   endtask

   task automatic ps2_bit(input logic b, input bit is_stop);
      @(posedge clk); #1 ps2_data = b;
      repeat (HALF - 1) @(posedge clk);
      #1 ps2_clk = 1'b0;
      for (int k = 1; k <= HALF; k++) begin
         @(posedge clk); #1;
         if (is_stop && lat < 0 && (valid | parity_err | frame_err)) lat = k;
      end
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      lat = -1;
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
      ps2_bit(par, 1'b0);
      ps2_bit(stop, 1'b1);
      repeat (5) @(posedge clk);
      #1;
   endtask

   initial begin
      int  fk;
      int  prev_busy;
      int  busy_at;
      logic [7:0] v3b;

      vt[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C};
      vt[1] = '{8'hF0, 1'b1, 1'b1, 1, 0, 0, 8'hF0};
      vt[2] = '{8'h00, 1'b1, 1'b1, 1, 0, 0, 8'h00};
      vt[3] = '{8'hA5, 1'b1, 1'b1, 1, 0, 0, 8'hA5};
      vt[4] = '{8'h1C, 1'b1, 1'b1, 0, 1, 0, 8'hA5};
      vt[5] = '{8'h1C, 1'b0, 1'b0, 0, 0, 1, 8'hA5};
      vt[6] = '{8'h1C, 1'b1, 1'b0, 0, 0, 1, 8'hA5};
      vt[7] = '{8'hFF, 1'b1, 1'b1, 1, 0, 0, 8'hFF};

      repeat (3) @(posedge clk);
      #1;
      check("reset_data", int'(data), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_pulses", int'(valid) + int'(parity_err) + int'(frame_err), 0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

      // Falling edge with data high while idle is ignored
      clear_counts();
      @(posedge clk); #1 ps2_data = 1'b1; ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      check("spurious_busy", int'(busy), 0);
      check("spurious_pulses", n_valid + n_perr + n_ferr, 0);

      for (int i = 0; i < 8; i++) begin
         clear_counts();
         send_frame(vt[i].d, vt[i].par, vt[i].stop);
         check($sformatf("v%0d_valid", i), n_valid, vt[i].ev);
         check($sformatf("v%0d_perr", i), n_perr, vt[i].ep);
         check($sformatf("v%0d_ferr", i), n_ferr, vt[i].ef);
         check($sformatf("v%0d_data", i), int'(data), int'(vt[i].ed));
         check($sformatf("v%0d_busy", i), int'(busy), 0);
         check($sformatf("v%0d_exclusive", i), n_multi, 0);
         check($sformatf("v%0d_latency", i), lat, SYNC + 1);
      end

      // Truncated frame: start + 3 data bits, then clock held high
      clear_counts();
      ps2_bit(1'b0, 1'b0);
      ps2_bit(1'b1, 1'b0);
      ps2_bit(1'b0, 1'b0);
      @(posedge clk); #1 ps2_data = 1'b1;
      repeat (HALF - 1) @(posedge clk);
      #1 ps2_clk = 1'b0;
      fk = -1; prev_busy = 0; busy_at = -1;
      for (int k = 1; k <= TMO + SYNC + 20; k++) begin
         @(posedge clk); #1;
         if (k == HALF) ps2_clk = 1'b1;
         if (frame_err && fk < 0) begin
            fk = k;
            busy_at = int'(busy);
            check("timeout_busy_before", prev_busy, 1);
         end
         prev_busy = int'(busy);
      end
      check("timeout_edge", fk, SYNC + TMO);
      check("timeout_busy_drop", busy_at, 0);
      check("timeout_ferr_count", n_ferr, 1);
      check("timeout_no_valid", n_valid, 0);
      clear_counts();
      send_frame(8'h5A, 1'b1, 1'b1);
      check("after_timeout_valid", n_valid, 1);
      check("after_timeout_data", int'(data), 8'h5A);

      // Reset after 5 bits of a frame
      clear_counts();
      v3b = 8'h3B;
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(v3b[i], 1'b0);
      check("midframe_busy", int'(busy), 1);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      check("async_reset_busy", int'(busy), 0);
      check("async_reset_data", int'(data), 0);
      check("async_reset_pulses", int'(valid) + int'(parity_err) + int'(frame_err), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("post_reset_no_err", n_valid + n_perr + n_ferr, 0);
      send_frame(8'h3B, 1'b0, 1'b1);
      check("post_reset_valid", n_valid, 1);
      check("post_reset_data", int'(data), 8'h3B);
      check("post_reset_errs", n_perr + n_ferr, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
